seg_scan_controller: RTL and testbench

//  Time-multiplexed scan controller for the 8-digit seven-segment display: two segment buses
//  (left group digits 7..4, right group digits 3..0), each with 4 tube selects.

---
 rtl/seg_scan_controller_pkg.sv | 33 +++
 rtl/seg_scan_controller_divider.sv | 43 ++++
 rtl/seg_scan_controller.sv | 113 +++++++++++
 tb/tb_seg_scan_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_controller_pkg.sv
// Shared definitions for the seven-segment scan controller: segment codes,
// scan state encoding and the per-digit visibility rule.
package seg_scan_controller_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam int NUM_DIGITS = 8;

  // Segment order is {a,b,c,d,e,f,g,dp}, 1 = lit
  localparam logic [7:0] SEG_0     = 8'b1111_1100;
  localparam logic [7:0] SEG_1     = 8'b0110_0000;
  localparam logic [7:0] SEG_2     = 8'b1101_1010;
  localparam logic [7:0] SEG_3     = 8'b1111_0010;
  localparam logic [7:0] SEG_4     = 8'b0110_0110;
  localparam logic [7:0] SEG_5     = 8'b1011_0110;
  localparam logic [7:0] SEG_6     = 8'b1011_1110;
  localparam logic [7:0] SEG_7     = 8'b1110_0000;
  localparam logic [7:0] SEG_8     = 8'b1111_1110;
  localparam logic [7:0] SEG_9     = 8'b1111_0110;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // A digit shows its code only when enabled and not in the dark half of a blink
  function automatic logic [7:0] digit_code(input logic [7:0] raw,
                                            input logic       en,
                                            input logic       blink,
                                            input logic       phase);
    return (en && !(blink && phase)) ? raw : SEG_BLANK;
  endfunction

endpackage

// File: rtl/seg_scan_controller_divider.sv
// Slot timer: counts cycles within a digit slot, steps the slot index 0..3,
// and tracks whether the slot is still in its blanking gap.
module seg_scan_controller_divider
  import seg_scan_controller_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [1:0]  slot,
  output scan_state_t state,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Slot counter and BLANK/SHOW sequencing; disabling parks the scan at slot 0 in BLANK
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      cnt   <= '0;
      slot  <= 2'd0;
      state <= ST_BLANK;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      slot  <= slot + 2'd1;
      state <= ST_BLANK;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == BLANK_LAST) begin
        state <= ST_SHOW;
      end
    end
  end

  assign frame_tick = enable && (cnt == CNT_LAST) && (slot == 2'd3);

endmodule

// File: rtl/seg_scan_controller.sv
// Eight-digit seven-segment scan controller: double-buffered frame with
// load/ack handshake, per-digit enable and blink, blanking gap per slot.
module seg_scan_controller
  import seg_scan_controller_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 125,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [63:0] digits_in,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  blink_mask,
  input  logic        load,
  output logic        load_ack,
  output logic        busy,
  output logic        frame_tick,
  output logic [7:0]  seg_left,
  output logic [7:0]  seg_right,
  output logic [7:0]  tub_sel
);

  localparam int             BF_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic [1:0]      slot;
  scan_state_t     state;
  logic [63:0]     shadow_digits, active_digits;
  logic [7:0]      shadow_en, shadow_blink, active_en, active_blink;
  logic [BF_W-1:0] blink_cnt;
  logic            blink_phase;
  logic            transfer;
  logic [2:0]      right_idx, left_idx;

  seg_scan_controller_divider #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .slot      (slot),
    .state     (state),
    .frame_tick(frame_tick)
  );

  // A fresh load always wins over a transfer in the same cycle, which defers that transfer
  assign transfer  = busy && !load && (frame_tick || !enable);
  assign right_idx = {1'b0, slot};
  assign left_idx  = {1'b1, slot};

  // Shadow capture, frame-boundary promotion to the active frame, and the ack pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_digits <= '0;
      shadow_en     <= '0;
      shadow_blink  <= '0;
      active_digits <= '0;
      active_en     <= '0;
      active_blink  <= '0;
      busy          <= 1'b0;
      load_ack      <= 1'b0;
    end else begin
      load_ack <= transfer;
      if (load) begin
        shadow_digits <= digits_in;
        shadow_en     <= digit_en;
        shadow_blink  <= blink_mask;
        busy          <= 1'b1;
      end else if (transfer) begin
        active_digits <= shadow_digits;
        active_en     <= shadow_en;
        active_blink  <= shadow_blink;
        busy          <= 1'b0;
      end
    end
  end

  // Blink phase flips every BLINK_FRAMES completed frames
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BF_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Registered pin drivers: one tube per group during SHOW, everything dark otherwise
  always_ff @(posedge clk) begin
    if (!rst_n || !enable || state == ST_BLANK) begin
      tub_sel   <= 8'h00;
      seg_right <= SEG_BLANK;
      seg_left  <= SEG_BLANK;
    end else begin
      tub_sel   <= (8'd1 << right_idx) | (8'd1 << left_idx);
      seg_right <= digit_code(active_digits[{right_idx, 3'b000} +: 8],
                              active_en[right_idx], active_blink[right_idx], blink_phase);
      seg_left  <= digit_code(active_digits[{left_idx, 3'b000} +: 8],
                              active_en[left_idx], active_blink[left_idx], blink_phase);
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller with a short scan (8-cycle slots, 2-cycle gap,
// 2-frame blink half-period). A cycle model derived from scan position arithmetic
// is compared against the DUT every cycle; directed literals pin key moments.
module tb_seg_scan_controller;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [63:0] digits_in;
  logic [7:0]  digit_en;
  logic [7:0]  blink_mask;
  logic        load;
  logic        load_ack;
  logic        busy;
  logic        frame_tick;
  logic [7:0]  seg_left;
  logic [7:0]  seg_right;
  logic [7:0]  tub_sel;

  int n_checks = 0;
  int n_pass   = 0;

  seg_scan_controller #(
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF),
    .CNT_W       (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .digits_in (digits_in),
    .digit_en  (digit_en),
    .blink_mask(blink_mask),
    .load      (load),
    .load_ack  (load_ack),
    .busy      (busy),
    .frame_tick(frame_tick),
    .seg_left  (seg_left),
    .seg_right (seg_right),
    .tub_sel   (tub_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
  endtask

  // Model state: scan position in cycles since the scan (re)started, plus frame buffers
  int          m_pos;
  int          m_frames;
  logic        m_phase;
  logic        m_busy;
  logic [63:0] m_sh_d, m_act_d;
  logic [7:0]  m_sh_en, m_sh_bl, m_act_en, m_act_bl;
  logic [7:0]  e_tub, e_segl, e_segr;
  logic        e_ack, e_tick;
  logic        model_valid = 1'b0;

  function automatic logic [7:0] expCode(input int k);
    if (m_act_en[k] && !(m_act_bl[k] && m_phase)) return m_act_d[k*8 +: 8];
    return 8'h00;
  endfunction

  // Model advances on each clock edge, then the DUT is compared 1 time unit later
  always @(posedge clk) begin
    int   cnt, slot;
    logic tick, xfer;
    if (!rst_n) begin
      m_pos = 0; m_frames = 0; m_phase = 1'b0; m_busy = 1'b0;
      m_sh_d = '0; m_sh_en = '0; m_sh_bl = '0;
      m_act_d = '0; m_act_en = '0; m_act_bl = '0;
      e_tub = '0; e_segl = '0; e_segr = '0; e_ack = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      cnt  = m_pos % SD;
      slot = (m_pos / SD) % 4;
      tick = enable && (cnt == SD - 1) && (slot == 3);
      if (enable && cnt >= BC) begin
        e_tub  = 8'(1 << slot) | 8'(1 << (slot + 4));
        e_segr = expCode(slot);
        e_segl = expCode(slot + 4);
      end else begin
        e_tub = '0; e_segl = '0; e_segr = '0;
      end
      xfer  = m_busy && !load && (tick || !enable);
      e_ack = xfer;
      if (load) begin
        m_sh_d = digits_in; m_sh_en = digit_en; m_sh_bl = blink_mask; m_busy = 1'b1;
      end else if (xfer) begin
        m_act_d = m_sh_d; m_act_en = m_sh_en; m_act_bl = m_sh_bl; m_busy = 1'b0;
      end
      if (tick) begin
        m_frames++;
        if (m_frames == BF) begin
          m_frames = 0;
          m_phase  = ~m_phase;
        end
      end
      m_pos = enable ? (m_pos + 1) % (4 * SD) : 0;
    end
    #1;
    if (model_valid) begin
      e_tick = enable && (m_pos % SD == SD - 1) && ((m_pos / SD) % 4 == 3);
      checkOutput("model_tub_sel", tub_sel, e_tub);
      checkOutput("model_seg_left", seg_left, e_segl);
      checkOutput("model_seg_right", seg_right, e_segr);
      checkOutput("model_load_ack", {7'b0, load_ack}, {7'b0, e_ack});
      checkOutput("model_busy", {7'b0, busy}, {7'b0, m_busy});
      checkOutput("model_frame_tick", {7'b0, frame_tick}, {7'b0, e_tick});
    end
  end

  // One-cycle load pulse starting at the current falling edge
  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] en, input logic [7:0] bl);
    digits_in  = d;
    digit_en   = en;
    blink_mask = bl;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next falling edge where frame_tick is high, bounded by a frame and a bit
  task automatic waitTick();
    int i;
    i = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && i < 4 * SD + 8) begin
      @(negedge clk);
      i++;
    end
    checkOutput("frame_tick_wait", {7'b0, frame_tick}, 8'h01);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; load = 1'b0;
    digits_in = '0; digit_en = '0; blink_mask = '0;

    // Reset state and first scan after release
    step(3);
    checkOutput("reset_tub_sel", tub_sel, 8'h00);
    checkOutput("reset_seg_left", seg_left, 8'h00);
    checkOutput("reset_seg_right", seg_right, 8'h00);
    checkOutput("reset_busy", {7'b0, busy}, 8'h00);
    checkOutput("reset_ack", {7'b0, load_ack}, 8'h00);
    rst_n = 1'b1;
    step(2);
    checkOutput("first_gap_tub", tub_sel, 8'h00);
    step(1);
    checkOutput("first_tub_sel", tub_sel, 8'h11);

    // Basic load, ack after boundary, new frame content
    applyStimulus(64'h0000_0060_0000_DAFC, 8'hFF, 8'h00);
    checkOutput("busy_after_load", {7'b0, busy}, 8'h01);
    waitTick();
    checkOutput("no_ack_in_tick", {7'b0, load_ack}, 8'h00);
    step(1);
    checkOutput("ack_after_tick", {7'b0, load_ack}, 8'h01);
    checkOutput("busy_cleared", {7'b0, busy}, 8'h00);
    step(1);
    checkOutput("slot0_blank_gap", tub_sel, 8'h00);
    step(2);
    checkOutput("slot0_tub", tub_sel, 8'h11);
    checkOutput("slot0_seg_right", seg_right, 8'hFC);
    checkOutput("slot0_seg_left", seg_left, 8'h60);
    step(8);
    checkOutput("slot1_tub", tub_sel, 8'h22);
    checkOutput("slot1_seg_right", seg_right, 8'hDA);

    // Two loads before a boundary: latest wins, one ack
    applyStimulus(64'h0000_0000_0000_00FC, 8'hFF, 8'h00);
    applyStimulus(64'h0000_0000_0000_0060, 8'hFF, 8'h00);
    waitTick();
    step(1);
    checkOutput("double_load_ack", {7'b0, load_ack}, 8'h01);
    step(1);
    checkOutput("single_ack", {7'b0, load_ack}, 8'h00);
    step(2);
    checkOutput("latest_wins", seg_right, 8'h60);

    // Load in the frame_tick cycle is held for a full frame
    waitTick();
    applyStimulus(64'h0000_0000_0000_003E, 8'hFF, 8'h00);
    checkOutput("tick_load_no_ack", {7'b0, load_ack}, 8'h00);
    checkOutput("tick_load_busy", {7'b0, busy}, 8'h01);
    waitTick();
    step(1);
    checkOutput("deferred_ack", {7'b0, load_ack}, 8'h01);
    step(3);
    checkOutput("deferred_data", seg_right, 8'h3E);

    // Blink on digit 0: lit in frame 5, dark in frames 6-7, lit again in frame 8
    applyStimulus(64'h0000_0000_0000_00B6, 8'hFF, 8'h01);
    waitTick();
    step(4);
    checkOutput("blink_lit_seg", seg_right, 8'hB6);
    waitTick();
    step(4);
    checkOutput("blink_dark_seg", seg_right, 8'h00);
    checkOutput("blink_dark_tub", tub_sel, 8'h11);
    waitTick();
    step(4);
    checkOutput("blink_dark2_seg", seg_right, 8'h00);
    waitTick();
    step(4);
    checkOutput("blink_relit_seg", seg_right, 8'hB6);

    // Enable dropped mid-slot 2 with a pending load
    applyStimulus(64'h0000_0000_0000_00C0, 8'hFF, 8'h00);
    step(16);
    checkOutput("slot2_before_disable", tub_sel, 8'h44);
    enable = 1'b0;
    step(1);
    checkOutput("disable_tub", tub_sel, 8'h00);
    checkOutput("disable_seg_left", seg_left, 8'h00);
    checkOutput("disable_ack", {7'b0, load_ack}, 8'h01);
    checkOutput("disable_busy", {7'b0, busy}, 8'h00);
    step(3);
    checkOutput("disabled_dark", tub_sel, 8'h00);
    enable = 1'b1;
    step(1);
    checkOutput("reenable_gap", tub_sel, 8'h00);
    step(2);
    checkOutput("reenable_tub", tub_sel, 8'h11);
    checkOutput("reenable_seg", seg_right, 8'hC0);

    // Reset during a pending handshake discards everything
    applyStimulus(64'h0000_0000_0000_00EE, 8'hFF, 8'h00);
    checkOutput("pre_reset_busy", {7'b0, busy}, 8'h01);
    rst_n = 1'b0;
    step(2);
    checkOutput("mid_reset_busy", {7'b0, busy}, 8'h00);
    checkOutput("mid_reset_ack", {7'b0, load_ack}, 8'h00);
    rst_n = 1'b1;
    step(3);
    checkOutput("post_reset_tub", tub_sel, 8'h11);
    checkOutput("post_reset_seg", seg_right, 8'h00);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
